// File: rtl/csr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | csr_pkg                                                                    |
// | Shared Zicsr encodings, FSM states and CSR map for csr_access_unit.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package csr_pkg;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [11:0] CSR_IDX_ALU = 12'h800;
  localparam logic [11:0] CSR_IDX_MUL = 12'h801;
  localparam logic [11:0] CSR_IDX_DIV = 12'h802;

  // Indices with both top bits set live in the read-only CSR space.
  localparam logic [11:0] CSR_RO_MASK = 12'hC00;

  function automatic logic csr_is_ro(input logic [11:0] idx);
    return (idx & CSR_RO_MASK) == CSR_RO_MASK;
  endfunction

endpackage
`default_nettype wire

// File: rtl/csr_access_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | csr_access_unit_if                                                         |
// | Read/write port bundle between the access unit and the CSR file.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface csr_access_unit_if;

  logic        read_enable_csr;
  logic        write_enable_csr;
  logic [11:0] csr_read_index;
  logic [11:0] csr_write_index;
  logic [31:0] csr_write_data;
  logic [31:0] csr_read_data;

  modport master (
    output read_enable_csr,
    output write_enable_csr,
    output csr_read_index,
    output csr_write_index,
    output csr_write_data,
    input  csr_read_data
  );

  modport slave (
    input  read_enable_csr,
    input  write_enable_csr,
    input  csr_read_index,
    input  csr_write_index,
    input  csr_write_data,
    output csr_read_data
  );

endinterface
`default_nettype wire

// File: rtl/csr_rmw_alu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | csr_rmw_alu                                                                |
// | Combinational new CSR value for write/set/clear Zicsr operations.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module csr_rmw_alu
  import csr_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] old_value,
  input  logic [31:0] operand,
  output logic [31:0] new_value
);

  always_comb begin
    new_value = old_value;
    case (funct3)
      F3_CSRRW, F3_CSRRWI: new_value = operand;
      F3_CSRRS, F3_CSRRSI: new_value = old_value | operand;
      F3_CSRRC, F3_CSRRCI: new_value = old_value & ~operand;
      default:             new_value = old_value;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/csr_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | csr_access_unit                                                            |
// | Sequences Zicsr instructions into read / write accesses on the CSR file.   |
// | Optional macro CSR_WRITE_COUNTER_EN adds a 32-bit csr_write_count output.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module csr_access_unit
  import csr_pkg::*;
#(
  parameter logic [11:0] CSR_BASE  = CSR_IDX_ALU,
  parameter int          CSR_COUNT = int'(CSR_IDX_DIV - CSR_IDX_ALU) + 1
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        funct3,
  input  logic [11:0]       csr_index,
  input  logic [31:0]       rs1_value,
  input  logic [4:0]        zimm,
  input  logic              rs1_is_zero,
  input  logic              rd_is_zero,
  input  logic              flush,
  csr_access_unit_if.master csr,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic [31:0]       rd_data
`ifdef CSR_WRITE_COUNTER_EN
  ,
  output logic [31:0]       csr_write_count
`endif
);

  localparam logic [12:0] IDX_END = 13'(CSR_BASE) + 13'(CSR_COUNT);

  state_t      state;
  logic [11:0] idx_q;
  logic [2:0]  f3_q;
  logic [31:0] operand_q;
  logic [31:0] old_value;
  logic        do_write_q;

  logic        is_imm;
  logic        is_rw;
  logic        f3_valid;
  logic        src_nonzero;
  logic        in_range;
  logic        do_read_in;
  logic        do_write_in;
  logic        req_illegal;
  logic [31:0] operand_in;
  logic [2:0]  alu_f3;
  logic [31:0] alu_old;
  logic [31:0] alu_operand;
  logic [31:0] new_value;

  assign is_imm      = funct3[2];
  assign operand_in  = is_imm ? {27'b0, zimm} : rs1_value;
  assign src_nonzero = is_imm ? (zimm != 5'd0) : !rs1_is_zero;
  assign is_rw       = (funct3 == F3_CSRRW) || (funct3 == F3_CSRRWI);
  assign f3_valid    = funct3 inside {F3_CSRRW, F3_CSRRS, F3_CSRRC,
                                      F3_CSRRWI, F3_CSRRSI, F3_CSRRCI};
  assign in_range    = ({1'b0, csr_index} >= 13'(CSR_BASE)) &&
                       ({1'b0, csr_index} <  IDX_END);
  assign do_read_in  = !(is_rw && rd_is_zero);
  assign do_write_in = is_rw || src_nonzero;
  assign req_illegal = !f3_valid || !in_range || (do_write_in && csr_is_ro(csr_index));

  // In IDLE only a write-only RW can be dispatched, so old_value is irrelevant there;
  // in READ the fresh CSR value feeds the ALU so the write data is ready next cycle.
  assign alu_f3      = (state == ST_IDLE) ? funct3     : f3_q;
  assign alu_operand = (state == ST_IDLE) ? operand_in : operand_q;
  assign alu_old     = (state == ST_READ) ? csr.csr_read_data : old_value;

  csr_rmw_alu u_rmw_alu (
    .funct3    (alu_f3),
    .old_value (alu_old),
    .operand   (alu_operand),
    .new_value (new_value)
  );

  assign busy = (state != ST_IDLE);

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state                <= ST_IDLE;
      idx_q                <= '0;
      f3_q                 <= '0;
      operand_q            <= '0;
      old_value            <= '0;
      do_write_q           <= 1'b0;
      done                 <= 1'b0;
      illegal              <= 1'b0;
      rd_data              <= '0;
      csr.read_enable_csr  <= 1'b0;
      csr.write_enable_csr <= 1'b0;
      csr.csr_read_index   <= '0;
      csr.csr_write_index  <= '0;
      csr.csr_write_data   <= '0;
    end else begin
      done                 <= 1'b0;
      illegal              <= 1'b0;
      csr.read_enable_csr  <= 1'b0;
      csr.write_enable_csr <= 1'b0;
      csr.csr_read_index   <= '0;
      csr.csr_write_index  <= '0;
      csr.csr_write_data   <= '0;
      case (state)
        ST_IDLE: begin
          if (start && !flush) begin
            if (req_illegal) begin
              illegal <= 1'b1;
            end else begin
              idx_q      <= csr_index;
              f3_q       <= funct3;
              operand_q  <= operand_in;
              do_write_q <= do_write_in;
              old_value  <= '0;
              if (do_read_in) begin
                state               <= ST_READ;
                csr.read_enable_csr <= 1'b1;
                csr.csr_read_index  <= csr_index;
              end else begin
                state                <= ST_WRITE;
                csr.write_enable_csr <= 1'b1;
                csr.csr_write_index  <= csr_index;
                csr.csr_write_data   <= new_value;
              end
            end
          end
        end
        ST_READ: begin
          if (flush) begin
            state <= ST_IDLE;
          end else begin
            old_value <= csr.csr_read_data;
            if (do_write_q) begin
              state                <= ST_WRITE;
              csr.write_enable_csr <= 1'b1;
              csr.csr_write_index  <= idx_q;
              csr.csr_write_data   <= new_value;
            end else begin
              state   <= ST_DONE;
              done    <= 1'b1;
              rd_data <= csr.csr_read_data;
            end
          end
        end
        ST_WRITE: begin
          state   <= ST_DONE;
          done    <= 1'b1;
          rd_data <= old_value;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef CSR_WRITE_COUNTER_EN
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      csr_write_count <= '0;
    end else if (csr.write_enable_csr) begin
      csr_write_count <= csr_write_count + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_csr_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_csr_access_unit                                                         |
// | Scoreboard bench for csr_access_unit; honours CSR_WRITE_COUNTER_EN.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_csr_access_unit;

  typedef struct {
    bit          ill;
    logic [31:0] rd;
    int          lat;
    int          t0;
  } resp_t;

  typedef struct {
    logic [11:0] idx;
    logic [31:0] data;
  } wr_t;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [11:0] csr_index = '0;
  logic [31:0] rs1_value = '0;
  logic [4:0]  zimm = '0;
  logic        rs1_is_zero = 1'b0;
  logic        rd_is_zero = 1'b0;
  logic        flush = 1'b0;
  logic        busy;
  logic        done;
  logic        illegal;
  logic [31:0] rd_data;
`ifdef CSR_WRITE_COUNTER_EN
  logic [31:0] csr_write_count;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int wcount = 0;

  logic [31:0] mem     [0:3] = '{default: 32'h0};
  logic [31:0] ref_mem [0:3] = '{default: 32'h0};

  resp_t       exp_resp [$];
  wr_t         exp_wr   [$];
  logic [11:0] exp_rd   [$];

  csr_access_unit_if bus ();

  csr_access_unit #(.CSR_BASE(12'h800), .CSR_COUNT(3)) dut (
    .CLK         (CLK),
    .reset       (reset),
    .start       (start),
    .funct3      (funct3),
    .csr_index   (csr_index),
    .rs1_value   (rs1_value),
    .zimm        (zimm),
    .rs1_is_zero (rs1_is_zero),
    .rd_is_zero  (rd_is_zero),
    .flush       (flush),
    .csr         (bus.master),
    .busy        (busy),
    .done        (done),
    .illegal     (illegal),
    .rd_data     (rd_data)
`ifdef CSR_WRITE_COUNTER_EN
    ,
    .csr_write_count (csr_write_count)
`endif
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // CSR file: combinational read, commit on the falling edge of the write cycle.
  assign bus.csr_read_data = (bus.read_enable_csr && bus.csr_read_index >= 12'h800 &&
                              bus.csr_read_index <= 12'h802) ? mem[bus.csr_read_index[1:0]] : 32'h0;
  always @(negedge CLK) begin
    if (bus.write_enable_csr && bus.csr_write_index >= 12'h800 && bus.csr_write_index <= 12'h802)
      mem[bus.csr_write_index[1:0]] <= bus.csr_write_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents an access or a response.
  always @(negedge CLK) begin
    if (reset) begin
      logic  zero_bad;
      resp_t r;
      wr_t   w;
      zero_bad = (!bus.read_enable_csr && bus.csr_read_index != 12'h0) ||
                 (!bus.write_enable_csr && (bus.csr_write_index != 12'h0 || bus.csr_write_data != 32'h0));
      check("bus_zero_when_idle", {31'b0, zero_bad}, 32'h0);
      if (bus.read_enable_csr) begin
        if (exp_rd.size() == 0) check("unexpected_read", 32'h1, 32'h0);
        else check("read_index", {20'b0, bus.csr_read_index}, {20'b0, exp_rd.pop_front()});
      end
      if (bus.write_enable_csr) begin
        if (exp_wr.size() == 0) check("unexpected_write", 32'h1, 32'h0);
        else begin
          w = exp_wr.pop_front();
          check("write_index", {20'b0, bus.csr_write_index}, {20'b0, w.idx});
          check("write_data", bus.csr_write_data, w.data);
        end
      end
      if (done || illegal) begin
        if (exp_resp.size() == 0) check("unexpected_response", 32'h1, 32'h0);
        else begin
          r = exp_resp.pop_front();
          check("resp_kind", {30'b0, done, illegal}, r.ill ? 32'h1 : 32'h2);
          if (!r.ill) check("rd_data", rd_data, r.rd);
          check("latency", 32'(cyc - r.t0 + 1), 32'(r.lat));
        end
      end
    end
  end

  // Drives one request and records what the instruction semantics say must follow.
  task automatic issue(input logic [2:0] f3, input logic [11:0] idx, input logic [31:0] rs1,
                       input logic [4:0] zi, input bit rs1z, input bit rdz,
                       input bit fl_read, input bit poke, input bit fl_start);
    int          kind;
    int          g;
    int          t0;
    bit          rd_op;
    bit          wr_op;
    bit          bad;
    logic [31:0] opnd;
    logic [31:0] oldv;
    logic [31:0] newv;
    g = 0;
    while (busy && g < 20) begin
      @(posedge CLK); #1;
      g++;
    end
    if (busy) begin
      check("idle_wait_timeout", {31'b0, busy}, 32'h0);
      return;
    end
    case (f3)
      3'b001, 3'b101: kind = 1;
      3'b010, 3'b110: kind = 2;
      3'b011, 3'b111: kind = 3;
      default:        kind = 0;
    endcase
    opnd  = f3[2] ? 32'(zi) : rs1;
    rd_op = !(kind == 1 && rdz);
    wr_op = (kind == 1) || (f3[2] ? (zi != 5'd0) : !rs1z);
    bad   = (kind == 0) || idx < 12'h800 || idx > 12'h802 || (wr_op && idx >= 12'hC00);
    oldv  = ref_mem[idx[1:0]];
    case (kind)
      1:       newv = opnd;
      2:       newv = oldv | opnd;
      3:       newv = oldv & ~opnd;
      default: newv = oldv;
    endcase
    funct3 = f3; csr_index = idx; rs1_value = rs1; zimm = zi;
    rs1_is_zero = rs1z; rd_is_zero = rdz;
    start = 1'b1; flush = fl_start;
    @(posedge CLK); #1;
    t0 = cyc;
    start = 1'b0; flush = 1'b0;
    if (fl_start) begin
      check("flush_with_start_dropped", {31'b0, busy}, 32'h0);
    end else if (bad) begin
      exp_resp.push_back('{1'b1, 32'h0, 1, t0});
    end else begin
      if (rd_op) exp_rd.push_back(idx);
      if (fl_read && rd_op) begin
        flush = 1'b1;
        @(posedge CLK); #1;
        flush = 1'b0;
        check("flush_in_read_idle", {31'b0, busy}, 32'h0);
      end else begin
        if (wr_op) begin
          exp_wr.push_back('{idx, newv});
          ref_mem[idx[1:0]] = newv;
          wcount++;
        end
        exp_resp.push_back('{1'b0, rd_op ? oldv : 32'h0, 1 + int'(rd_op) + int'(wr_op), t0});
        if (poke) begin
          check("busy_during_op", {31'b0, busy}, 32'h1);
          start = 1'b1; funct3 = 3'($urandom); csr_index = 12'h800 + 12'($urandom_range(0, 2));
          @(posedge CLK); #1;
          start = 1'b0;
        end
      end
    end
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_resp.size() != 0 || exp_wr.size() != 0 || exp_rd.size() != 0 || busy) && g < 50) begin
      @(posedge CLK); #1;
      g++;
    end
    if (g >= 50) begin
      check("drain_timeout", 32'(exp_resp.size() + exp_wr.size() + exp_rd.size()), 32'h0);
      exp_resp.delete(); exp_wr.delete(); exp_rd.delete();
    end
  endtask

  initial begin
    logic [31:0] saved [0:3];
    #1;
    check("reset_busy",    {31'b0, busy},    32'h0);
    check("reset_done",    {31'b0, done},    32'h0);
    check("reset_illegal", {31'b0, illegal}, 32'h0);
    check("reset_rd_data", rd_data,          32'h0);
    check("reset_re",      {31'b0, bus.read_enable_csr},  32'h0);
    check("reset_we",      {31'b0, bus.write_enable_csr}, 32'h0);
    repeat (2) @(posedge CLK);
    #1 reset = 1'b1;
    @(posedge CLK); #1;

    // Directed scenarios; preloads go through the unit as write-only CSRRW.
    issue(3'b001, 12'h800, 32'h0000_1234, 5'd0, 1'b0, 1'b1, 0, 0, 0);
    issue(3'b001, 12'h800, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 0, 0, 0);
    issue(3'b101, 12'h801, 32'h0,         5'd7, 1'b1, 1'b1, 0, 0, 0);
    issue(3'b001, 12'h802, 32'h0000_00A5, 5'd0, 1'b0, 1'b1, 0, 0, 0);
    issue(3'b010, 12'h802, 32'h0,         5'd0, 1'b1, 1'b0, 0, 0, 0);
    issue(3'b001, 12'h800, 32'h0000_00FF, 5'd0, 1'b0, 1'b1, 0, 0, 0);
    issue(3'b011, 12'h800, 32'h0000_000F, 5'd0, 1'b0, 1'b0, 0, 1, 0);
    issue(3'b100, 12'h800, 32'h1,         5'd0, 1'b0, 1'b0, 0, 0, 0);
    issue(3'b001, 12'h803, 32'h1,         5'd0, 1'b0, 1'b0, 0, 0, 0);
    issue(3'b001, 12'hC00, 32'h1,         5'd0, 1'b0, 1'b0, 0, 0, 0);
    issue(3'b001, 12'h801, 32'h3333_4444, 5'd0, 1'b0, 1'b0, 1, 0, 0);
    issue(3'b001, 12'h801, 32'h5555_6666, 5'd0, 1'b0, 1'b0, 0, 0, 1);
    drain();
    check("directed_mem800", mem[0], 32'h0000_00F0);
    check("directed_mem801", mem[1], 32'h0000_0007);

    for (int i = 0; i < 200; i++) begin
      logic [2:0]  f3;
      logic [11:0] idx;
      logic [31:0] rs1;
      logic [4:0]  zi;
      bit          rs1z;
      int          sel;
      f3   = 3'($urandom_range(0, 7));
      sel  = $urandom_range(0, 9);
      idx  = (sel == 0) ? 12'h7FF : (sel == 1) ? 12'h803 : (sel == 2) ? 12'hC01 :
             12'h800 + 12'($urandom_range(0, 2));
      rs1z = ($urandom_range(0, 3) == 0);
      rs1  = rs1z ? 32'h0 : $urandom;
      zi   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      issue(f3, idx, rs1, zi, rs1z, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0), ($urandom_range(0, 19) == 0));
    end
    drain();
    for (int k = 0; k < 3; k++) check("final_mem", mem[k], ref_mem[k]);
`ifdef CSR_WRITE_COUNTER_EN
    check("write_count", csr_write_count, 32'(wcount));
`endif

    // Asynchronous reset landing in the middle of a write-only access.
    for (int k = 0; k < 4; k++) saved[k] = mem[k];
    funct3 = 3'b001; csr_index = 12'h801; rs1_value = 32'h5555_AAAA;
    rs1_is_zero = 1'b0; rd_is_zero = 1'b1; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    check("pre_reset_we", {31'b0, bus.write_enable_csr}, 32'h1);
    #1 reset = 1'b0;
    #1;
    check("async_reset_we",   {31'b0, bus.write_enable_csr}, 32'h0);
    check("async_reset_busy", {31'b0, busy}, 32'h0);
    check("async_reset_done", {31'b0, done}, 32'h0);
    repeat (2) @(posedge CLK);
    #1 reset = 1'b1;
    check("post_reset_rd_data", rd_data, 32'h0);
`ifdef CSR_WRITE_COUNTER_EN
    check("post_reset_count", csr_write_count, 32'h0);
`endif
    repeat (3) @(posedge CLK);
    #1;
    for (int k = 0; k < 3; k++) check("no_commit_after_reset", mem[k], saved[k]);
    check("no_response_after_reset", 32'(exp_resp.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
